// File: rtl/nios_rx_read_ctrl_pkg.sv
// Shared types and constants for the Nios UART receive read controller.
package nios_rx_read_ctrl_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 3;
  localparam int unsigned DROP_W     = 8;

  localparam logic [DROP_W-1:0] DROP_MAX = 8'd255;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESENT  = 2'd1,
    WAIT_REL = 2'd2
  } state_t;

endpackage

// File: rtl/nios_rx_fifo.sv
// Small synchronous FIFO; dout shows the head entry combinationally.
module nios_rx_fifo
  import nios_rx_read_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [ADDR_W:0]   level,
  output logic              full,
  output logic              empty
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;

  // Storage carries no reset; only the pointers and level define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + ADDR_W'(1);
      end
      if (pop) begin
        rptr <= rptr + ADDR_W'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + (ADDR_W+1)'(1);
        2'b01:   level <= level - (ADDR_W+1)'(1);
        default: level <= level;
      endcase
    end
  end

  assign dout  = mem[rptr];
  assign full  = (level == (ADDR_W+1)'(DEPTH));
  assign empty = (level == '0);

endmodule

// File: rtl/nios_rx_read_ctrl.sv
// Presents buffered UART bytes to the Nios via a four-phase PIO handshake,
// with sticky overflow and saturating dropped-byte count.
module nios_rx_read_ctrl
  import nios_rx_read_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rd_req,
  output logic              rd_avail,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W:0]   fifo_level,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_cnt,
  input  logic              ovf_clr
);

  state_t            state;
  state_t            state_next;
  logic              pop_c;
  logic              push_c;
  logic              drop_c;
  logic              full;
  logic              empty;
  logic [DATA_W-1:0] fifo_dout;

  nios_rx_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_c),
    .pop     (pop_c),
    .din     (rx_data),
    .dout    (fifo_dout),
    .level   (fifo_level),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A load waits for rd_req low so each req high phase consumes one byte.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (!empty && !rd_req) state_next = PRESENT;
      PRESENT:  if (rd_req)            state_next = WAIT_REL;
      WAIT_REL: if (!rd_req)           state_next = IDLE;
      default:                         state_next = IDLE;
    endcase
  end

  // A pop frees a slot in the same cycle, so a push into a full FIFO is kept.
  always_comb begin
    pop_c  = 1'b0;
    push_c = 1'b0;
    drop_c = 1'b0;
    if (state == IDLE) begin
      pop_c = !empty && !rd_req;
    end
    push_c = rx_valid && (!full || pop_c);
    drop_c = rx_valid && full && !pop_c;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_avail <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_avail <= (state_next == PRESENT);
      if (pop_c) begin
        rd_data <= fifo_dout;
      end
    end
  end

  // Clear takes priority over a coincident drop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop_c) begin
      overflow <= 1'b1;
      if (drop_cnt != DROP_MAX) begin
        drop_cnt <= drop_cnt + DROP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_nios_rx_read_ctrl.sv
// Directed bench for nios_rx_read_ctrl with a queue-based reference model
// checked every cycle, plus literal spot checks.
module tb_nios_rx_read_ctrl;

  logic       clk;
  logic       reset_n;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rd_req;
  logic       rd_avail;
  logic [7:0] rd_data;
  logic [3:0] fifo_level;
  logic       overflow;
  logic [7:0] drop_cnt;
  logic       ovf_clr;

  int checks;
  int failures;

  nios_rx_read_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rd_req     (rd_req),
    .rd_avail   (rd_avail),
    .rd_data    (rd_data),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt),
    .ovf_clr    (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: stored bytes in a queue, one presented byte, and a flag
  // that blocks the next load until software releases rd_req.
  logic [7:0] q[$];
  logic       m_avail;
  logic [7:0] m_data;
  logic       m_hold;
  logic       m_ovf;
  logic [7:0] m_cnt;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      m_avail = 1'b0;
      m_data  = 8'h00;
      m_hold  = 1'b0;
      m_ovf   = 1'b0;
      m_cnt   = 8'h00;
    end else begin
      bit m_pop;
      bit m_full;
      m_full = (q.size() == 8);
      m_pop  = !m_avail && !m_hold && !rd_req && (q.size() > 0);
      if (m_pop) begin
        m_data  = q.pop_front();
        m_avail = 1'b1;
      end else if (m_avail && rd_req) begin
        m_avail = 1'b0;
        m_hold  = 1'b1;
      end else if (m_hold && !rd_req) begin
        m_hold = 1'b0;
      end
      if (rx_valid && (!m_full || m_pop)) q.push_back(rx_data);
      if (ovf_clr) begin
        m_ovf = 1'b0;
        m_cnt = 8'h00;
      end else if (rx_valid && m_full && !m_pop) begin
        m_ovf = 1'b1;
        if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'h01;
      end
    end
  end

  always @(negedge clk) begin
    check("model rd_avail",   int'(rd_avail),   int'(m_avail));
    check("model rd_data",    int'(rd_data),    int'(m_data));
    check("model fifo_level", int'(fifo_level), q.size());
    check("model overflow",   int'(overflow),   int'(m_ovf));
    check("model drop_cnt",   int'(drop_cnt),   int'(m_cnt));
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    rx_valid = 1'b1;
    rx_data  = d;
    step(1);
    rx_valid = 1'b0;
  endtask

  task automatic consume();
    rd_req = 1'b1;
    step(1);
    rd_req = 1'b0;
    step(1);
  endtask

  // Wait (bounded) for a presented byte, check it and consume it.
  task automatic take(input string name, input logic [7:0] exp);
    int n;
    n = 0;
    while (!rd_avail && n < 6) begin
      step(1);
      n++;
    end
    check({name, " avail"}, int'(rd_avail), 1);
    check({name, " data"},  int'(rd_data),  int'(exp));
    consume();
  endtask

  task automatic reset_dut();
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(1);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    rd_req   = 1'b0;
    ovf_clr  = 1'b0;
    step(2);
    check("reset rd_avail",   int'(rd_avail),   0);
    check("reset rd_data",    int'(rd_data),    0);
    check("reset fifo_level", int'(fifo_level), 0);
    check("reset overflow",   int'(overflow),   0);
    check("reset drop_cnt",   int'(drop_cnt),   0);
    reset_n = 1'b1;
    step(1);

    // Single byte latency
    push(8'h5A);
    check("t1 level N+1", int'(fifo_level), 1);
    check("t1 avail N+1", int'(rd_avail),   0);
    step(1);
    check("t1 avail N+2", int'(rd_avail),   1);
    check("t1 data N+2",  int'(rd_data),    8'h5A);
    check("t1 level N+2", int'(fifo_level), 0);

    // Handshake; a second byte waits until req is released
    rd_req   = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'hA7;
    step(1);
    rx_valid = 1'b0;
    check("t2 avail drop", int'(rd_avail), 0);
    check("t2 data held",  int'(rd_data),  8'h5A);
    step(2);
    check("t2 no load while req", int'(rd_avail), 0);
    rd_req = 1'b0;
    step(1);
    check("t2 not yet", int'(rd_avail), 0);
    step(1);
    check("t2 avail 2nd", int'(rd_avail), 1);
    check("t2 data 2nd",  int'(rd_data),  8'hA7);
    consume();

    // Fill to capacity (8 stored + 1 presented), then one drop
    for (int i = 1; i <= 9; i++) push(8'(i));
    check("t3 level",    int'(fifo_level), 8);
    check("t3 data",     int'(rd_data),    8'h01);
    check("t3 overflow", int'(overflow),   0);
    push(8'h0A);
    check("t3 ovf after drop", int'(overflow), 1);
    check("t3 drop_cnt",       int'(drop_cnt), 1);
    for (int i = 1; i <= 9; i++) take("t3 drain", 8'(i));
    step(2);
    check("t3 empty", int'(fifo_level), 0);

    // Clear, then push into a full FIFO on the cycle of the IDLE pop
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    check("t4 clr ovf", int'(overflow), 0);
    for (int i = 0; i < 9; i++) push(8'h11 + 8'(i));
    check("t4 full", int'(fifo_level), 8);
    consume();
    push(8'h44);
    check("t4 ovf",   int'(overflow),   0);
    check("t4 level", int'(fifo_level), 8);
    check("t4 data",  int'(rd_data),    8'h12);
    consume();
    for (int i = 0; i < 7; i++) take("t4 drain", 8'h13 + 8'(i));
    take("t4 last", 8'h44);

    // rd_req held high through reset release
    rd_req = 1'b1;
    reset_dut();
    push(8'h33);
    step(2);
    check("t5 blocked avail", int'(rd_avail),   0);
    check("t5 blocked level", int'(fifo_level), 1);
    rd_req = 1'b0;
    step(1);
    check("t5 avail", int'(rd_avail), 1);
    check("t5 data",  int'(rd_data),  8'h33);
    consume();

    // Saturation and clear-wins
    for (int i = 0; i < 9; i++) push(8'h80 + 8'(i));
    rx_valid = 1'b1;
    rx_data  = 8'hEE;
    step(300);
    rx_valid = 1'b0;
    check("t6 overflow", int'(overflow), 1);
    check("t6 sat",      int'(drop_cnt), 255);
    rx_valid = 1'b1;
    ovf_clr  = 1'b1;
    step(1);
    rx_valid = 1'b0;
    ovf_clr  = 1'b0;
    check("t6 clr ovf", int'(overflow), 0);
    check("t6 clr cnt", int'(drop_cnt), 0);

    // Reset while a byte is presented
    check("t6 present", int'(rd_avail), 1);
    reset_n = 1'b0;
    #1;
    check("t6 rst avail", int'(rd_avail),   0);
    check("t6 rst data",  int'(rd_data),    0);
    check("t6 rst level", int'(fifo_level), 0);
    step(1);
    reset_n = 1'b1;
    step(3);
    check("t6 post avail", int'(rd_avail),   0);
    check("t6 post level", int'(fifo_level), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
